// File: rtl/bpu_pkg.sv
// Shared types and counter constants for the fetch-pair branch predictor.
// Entry fields are sized for the widest supported tag/counter; narrower configs zero-extend.
package bpu_pkg;

  localparam int TAG_W = 24;
  localparam int CTR_W = 8;

  typedef logic [CTR_W-1:0] ctr_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [31:0]       target;
    ctr_t              ctr;
  } btb_entry_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic        is_cond;
  } upd_info_t;

  // Weakly-taken value: only the counter MSB set.
  function automatic ctr_t ctr_init(input int bits);
    return ctr_t'(1) << (bits - 1);
  endfunction

  function automatic ctr_t ctr_max(input int bits);
    return ctr_t'((64'd1 << bits) - 64'd1);
  endfunction

endpackage

// File: rtl/bpu_btb_bank.sv
// BTB storage: two registered lookup read ports, one write port with a read-modify-write view.
// Valid bits live in flops so reset can clear them; payload fields are plain RAM arrays.
module bpu_btb_bank
  import bpu_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             rd_en,
  input  logic [IW-1:0]    rd_idx [2],
  output btb_entry_t       rd_data [2],
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_idx,
  input  btb_entry_t       wr_data,
  output btb_entry_t       wr_old
);

  logic [DEPTH-1:0] valid_reg;
  logic [TAG_W-1:0] tag_mem    [DEPTH];
  logic [31:0]      target_mem [DEPTH];
  ctr_t             ctr_mem    [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) valid_reg <= '0;
    else if (wr_en) valid_reg[wr_idx] <= wr_data.valid;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]    <= wr_data.tag;
      target_mem[wr_idx] <= wr_data.target;
      ctr_mem[wr_idx]    <= wr_data.ctr;
    end
  end

  // Reads sample pre-write contents, so a same-index update is never forwarded.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rd_data[gi] <= '0;
      else if (rd_en)
        rd_data[gi] <= '{valid:  valid_reg[rd_idx[gi]],
                         tag:    tag_mem[rd_idx[gi]],
                         target: target_mem[rd_idx[gi]],
                         ctr:    ctr_mem[rd_idx[gi]]};
    end
  end

  assign wr_old = '{valid:  valid_reg[wr_idx],
                    tag:    tag_mem[wr_idx],
                    target: target_mem[wr_idx],
                    ctr:    ctr_mem[wr_idx]};

endmodule

// File: rtl/param_bpu.sv
// Two-slot fetch branch predictor (BTB + saturating counters), one-cycle lookup.
// Define BPU_GSHARE_EN to move counters into a GHR-xor-indexed table.
module param_bpu
  import bpu_pkg::*;
#(
  parameter int BTB_DEPTH = 64,
  parameter int TAG_BITS  = 10,
  parameter int CTR_BITS  = 2,
  parameter int GHR_BITS  = 6
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stallreq,
  input  logic        flush,
  input  logic [31:0] pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_is_cond,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        pred_slot,
  output logic        pred_dely
);

  localparam int   IW       = $clog2(BTB_DEPTH);
  localparam ctr_t CTR_INIT = ctr_init(CTR_BITS);
  localparam ctr_t CTR_MAX  = ctr_max(CTR_BITS);

  function automatic logic [IW-1:0] idx_of(input logic [31:0] a);
    return a[IW+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] a);
    return TAG_W'(a[IW+2 +: TAG_BITS]);
  endfunction

  logic             rd_en;
  logic [IW-1:0]    rd_idx [2];
  btb_entry_t       rd_data [2];
  logic [TAG_W-1:0] tag_reg [2];
  ctr_t             look_ctr [2];
  logic [1:0]       hit;
  logic             look_vld_reg;
  logic             prev_dely_reg;

  upd_info_t        upd;
  logic [IW-1:0]    upd_idx;
  logic             upd_hit;
  ctr_t             upd_ctr_old;
  ctr_t             upd_ctr_new;
  logic             wr_en;
  btb_entry_t       wr_data;
  btb_entry_t       btb_old;

  assign rd_en     = !stallreq && !flush;
  assign rd_idx[0] = idx_of(pc);
  assign rd_idx[1] = idx_of(pc + 32'd4);

  assign upd     = '{valid: upd_valid, pc: upd_pc, taken: upd_taken,
                     target: upd_target, is_cond: upd_is_cond};
  assign upd_idx = idx_of(upd.pc);
  assign upd_hit = btb_old.valid && (btb_old.tag == tag_of(upd.pc));

  bpu_btb_bank #(.DEPTH(BTB_DEPTH), .IW(IW)) u_bank (
    .clk     (clk),
    .resetn  (resetn),
    .rd_en   (rd_en),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_idx  (upd_idx),
    .wr_data (wr_data),
    .wr_old  (btb_old)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      look_vld_reg  <= 1'b0;
      prev_dely_reg <= 1'b0;
      tag_reg       <= '{default: '0};
    end else if (flush) begin
      look_vld_reg  <= 1'b0;
      prev_dely_reg <= 1'b0;
    end else if (!stallreq) begin
      look_vld_reg  <= 1'b1;
      prev_dely_reg <= pred_dely;
      tag_reg[0]    <= tag_of(pc);
      tag_reg[1]    <= tag_of(pc + 32'd4);
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_hit
    assign hit[gi] = look_vld_reg && rd_data[gi].valid &&
                     (rd_data[gi].tag == tag_reg[gi]) && (look_ctr[gi] >= CTR_INIT);
  end

  // Slot1 hit right after a slot1 prediction belongs to the unfetched delay-slot pair.
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = '0;
    pred_slot   = 1'b0;
    pred_dely   = 1'b0;
    if (!(hit[1] && prev_dely_reg)) begin
      if (hit[0]) begin
        pred_taken  = 1'b1;
        pred_target = rd_data[0].target;
      end else if (hit[1]) begin
        pred_taken  = 1'b1;
        pred_target = rd_data[1].target;
        pred_slot   = 1'b1;
        pred_dely   = 1'b1;
      end
    end
  end

  always_comb begin
    wr_en       = 1'b0;
    upd_ctr_new = upd_ctr_old;
    if (upd.valid) begin
      if (!upd.is_cond) begin
        wr_en       = 1'b1;
        upd_ctr_new = CTR_MAX;
      end else if (upd_hit) begin
        wr_en = 1'b1;
        if (upd.taken && upd_ctr_old != CTR_MAX) upd_ctr_new = upd_ctr_old + ctr_t'(1);
        else if (!upd.taken && upd_ctr_old != '0) upd_ctr_new = upd_ctr_old - ctr_t'(1);
      end else if (upd.taken) begin
        wr_en       = 1'b1;
        upd_ctr_new = CTR_INIT;
      end
    end
    wr_data = '{valid: 1'b1, tag: tag_of(upd.pc), target: upd.target, ctr: upd_ctr_new};
  end

`ifdef BPU_GSHARE_EN
  logic [GHR_BITS-1:0] ghr_reg;
  ctr_t                ctr_mem [BTB_DEPTH];
  logic [IW-1:0]       upd_cidx;

  assign upd_cidx    = upd_idx ^ IW'(ghr_reg);
  assign upd_ctr_old = ctr_mem[upd_cidx];

  always_ff @(posedge clk) begin
    if (wr_en) ctr_mem[upd_cidx] <= upd_ctr_new;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ghr_reg <= '0;
    else if (upd.valid && upd.is_cond) ghr_reg <= GHR_BITS'({ghr_reg, upd.taken});
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_ctr_rd
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) look_ctr[gi] <= '0;
      else if (rd_en) look_ctr[gi] <= ctr_mem[rd_idx[gi] ^ IW'(ghr_reg)];
    end
  end
`else
  assign upd_ctr_old = btb_old.ctr;
  for (genvar gi = 0; gi < 2; gi++) begin : g_ctr_rd
    assign look_ctr[gi] = rd_data[gi].ctr;
  end
`endif

endmodule

// File: tb/tb_param_bpu.sv
// Scoreboard bench for param_bpu: expected predictions queued at drive time,
// compared one cycle later when the lookup result appears.
module tb_param_bpu;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stallreq;
  logic        flush;
  logic [31:0] pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_is_cond;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pred_slot;
  logic        pred_dely;

  localparam logic [31:0] IDLE_PC = 32'h0000_8000;
  localparam logic [34:0] MISS    = 35'd0;

  int checks = 0;
  int errors = 0;
  string       name_q[$];
  logic [34:0] exp_q[$];

  always #5 clk = ~clk;

  param_bpu dut (
    .clk         (clk),
    .resetn      (resetn),
    .stallreq    (stallreq),
    .flush       (flush),
    .pc          (pc),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .upd_is_cond (upd_is_cond),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .pred_slot   (pred_slot),
    .pred_dely   (pred_dely)
  );

  function automatic logic [34:0] s0(input logic [31:0] t);
    return {1'b1, 1'b0, 1'b0, t};
  endfunction

  function automatic logic [34:0] s1(input logic [31:0] t);
    return {1'b1, 1'b1, 1'b1, t};
  endfunction

  function automatic logic [34:0] outs();
    return {pred_taken, pred_slot, pred_dely, pred_target};
  endfunction

  // Values are {taken, slot, dely, target[31:0]}.
  task automatic check_val(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("pass %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    string       nm;
    logic [34:0] ex;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    flush     = 1'b0;
    if (exp_q.size() > 0) begin
      nm = name_q.pop_front();
      ex = exp_q.pop_front();
      check_val(nm, outs(), ex);
    end
  endtask

  task automatic drive(input string nm, input logic [31:0] a, input logic stall,
                       input logic fl, input logic [34:0] ex);
    pc       = a;
    stallreq = stall;
    flush    = fl;
    name_q.push_back(nm);
    exp_q.push_back(ex);
    tick();
  endtask

  task automatic set_upd(input logic [31:0] a, input logic tk, input logic [31:0] tgt,
                         input logic cond);
    upd_valid   = 1'b1;
    upd_pc      = a;
    upd_taken   = tk;
    upd_target  = tgt;
    upd_is_cond = cond;
  endtask

  task automatic idle(input string nm);
    drive(nm, IDLE_PC, 1'b0, 1'b0, MISS);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; stallreq = 1'b0; flush = 1'b0; pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_is_cond = 1'b0;
    #11;
    check_val("reset_state", outs(), MISS);
    #1 resetn = 1'b1;

    drive("first_lookup", 32'h1000, 1'b0, 1'b0, MISS);
    set_upd(32'h1000, 1'b1, 32'h2000, 1'b1); idle("alloc_cycle");
    drive("slot0_hit", 32'h1000, 1'b0, 1'b0, s0(32'h2000));
    drive("slot1_hit", 32'h0FFC, 1'b0, 1'b0, s1(32'h2000));
    drive("dely_suppress", 32'h0FFC, 1'b0, 1'b0, MISS);
    drive("slot1_again", 32'h0FFC, 1'b0, 1'b0, s1(32'h2000));
    drive("slot0_after_dely", 32'h1000, 1'b0, 1'b0, s0(32'h2000));

    set_upd(32'h1104, 1'b1, 32'h3000, 1'b0); idle("jtype_cycle");
    drive("jtype_slot1", 32'h1100, 1'b0, 1'b0, s1(32'h3000));

    set_upd(32'h1000, 1'b0, 32'h2000, 1'b1);
    drive("read_before_write", 32'h1000, 1'b0, 1'b0, s0(32'h2000));
    drive("ctr_one_miss", 32'h1000, 1'b0, 1'b0, MISS);
    set_upd(32'h1000, 1'b1, 32'h2400, 1'b1); idle("retarget_cycle");
    drive("retarget", 32'h1000, 1'b0, 1'b0, s0(32'h2400));
    set_upd(32'h2000, 1'b0, 32'h5000, 1'b1); idle("nt_miss_cycle");
    drive("nt_miss_nowrite", 32'h1000, 1'b0, 1'b0, s0(32'h2400));

    set_upd(32'h1000, 1'b0, 32'h2400, 1'b1); idle("nt_a");
    set_upd(32'h1000, 1'b0, 32'h2400, 1'b1); idle("nt_b");
    drive("two_nt_miss", 32'h1000, 1'b0, 1'b0, MISS);
    set_upd(32'h1000, 1'b0, 32'h2400, 1'b1); idle("nt_at_zero");
    drive("sat_low", 32'h1000, 1'b0, 1'b0, MISS);
    set_upd(32'h1000, 1'b1, 32'h2400, 1'b1); idle("tk_a");
    set_upd(32'h1000, 1'b1, 32'h2400, 1'b1); idle("tk_b");
    drive("ctr_rise_hit", 32'h1000, 1'b0, 1'b0, s0(32'h2400));

    set_upd(32'h1104, 1'b1, 32'h3000, 1'b1); idle("tk_at_max");
    set_upd(32'h1104, 1'b0, 32'h3000, 1'b1); idle("nt_from_max");
    drive("sat_high_a", 32'h1100, 1'b0, 1'b0, s1(32'h3000));
    set_upd(32'h1104, 1'b0, 32'h3000, 1'b1); idle("nt_to_one");
    drive("sat_high_b", 32'h1100, 1'b0, 1'b0, MISS);
    set_upd(32'h1104, 1'b1, 32'h3100, 1'b0); idle("jtype_force");
    set_upd(32'h1104, 1'b0, 32'h3100, 1'b1); idle("nt_after_j");
    drive("jtype_max", 32'h1100, 1'b0, 1'b0, s1(32'h3100));

    drive("pre_stall", 32'h1000, 1'b0, 1'b0, s0(32'h2400));
    drive("stall_hold", 32'h1100, 1'b1, 1'b0, s0(32'h2400));
    set_upd(32'h1000, 1'b0, 32'h2400, 1'b1);
    drive("stall_flush", 32'h0FFC, 1'b1, 1'b1, MISS);
    drive("stall_after_flush", 32'h1000, 1'b1, 1'b0, MISS);
    drive("post_stall", 32'h1100, 1'b0, 1'b0, s1(32'h3100));
    drive("upd_during_stall", 32'h1000, 1'b0, 1'b0, MISS);

    set_upd(32'h1000, 1'b1, 32'h2400, 1'b1); idle("rearm");
    drive("pre_reset", 32'h1000, 1'b0, 1'b0, s0(32'h2400));
    #2 resetn = 1'b0;
    #1 check_val("async_reset", outs(), MISS);
    resetn = 1'b1;
    drive("post_reset_s0", 32'h1000, 1'b0, 1'b0, MISS);
    drive("post_reset_s1", 32'h1100, 1'b0, 1'b0, MISS);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
